// File: rtl/piso_tx_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// piso_tx_scheduler_if : requester/serializer bundle for piso_tx_scheduler
// Rev 1.0
// ------------------------------------------------------------------------
interface piso_tx_scheduler_if #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic                   done;
  logic                   sr_load;
  logic                   sr_enable;
  logic [WIDTH-1:0]       sr_pi;

  modport master (
    output req, data_in,
    input  grant, busy, done, sr_load, sr_enable, sr_pi
  );

  modport slave (
    input  req, data_in,
    output grant, busy, done, sr_load, sr_enable, sr_pi
  );
endinterface
`default_nettype wire

// File: rtl/piso_tx_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// piso_tx_scheduler : round-robin arbiter and bit-rate pacer for one PISO
// serializer, with idle-high gap bits between frames.          Rev 1.0
// ------------------------------------------------------------------------
module piso_tx_scheduler #(
  parameter int N_REQ    = 3,
  parameter int WIDTH    = 32,
  parameter int CLK_DIV  = 16,
  parameter int GAP_BITS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  piso_tx_scheduler_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(WIDTH + GAP_BITS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic             enable_q, enable_d;
  logic [WIDTH-1:0] pi_q, pi_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand;
  logic [WIDTH-1:0] win_word;
  logic             tick;

  // Search upward from the pointer, wrapping, for the first pending request.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_word = bus.data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign tick = ((state_q == S_SHIFT) || (state_q == S_GAP)) &&
                (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      pi_q     <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      load_q   <= load_d;
      enable_q <= enable_d;
      pi_q     <= pi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        cnt_d = '0;
        if (win_found) begin
          state_d = S_LOAD;
          ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      S_LOAD: begin
        div_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = (GAP_BITS == 0) ? S_IDLE : S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          if (cnt_q == CNT_W'(GAP_BITS - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    grant_d  = '0;
    load_d   = 1'b0;
    enable_d = 1'b0;
    done_d   = 1'b0;
    pi_d     = pi_q;
    busy_d   = (state_d != S_IDLE);
    if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
      grant_d[win_idx] = 1'b1;
      load_d           = 1'b1;
      enable_d         = 1'b1;
      pi_d             = win_word;
    end
    if (((state_d == S_SHIFT) || (state_d == S_GAP)) &&
        (div_d == DIV_W'(CLK_DIV - 1))) begin
      enable_d = 1'b1;
    end
    if (((state_q == S_SHIFT) || (state_q == S_GAP)) && (state_d == S_IDLE)) begin
      done_d = 1'b1;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sr_load   = load_q;
  assign bus.sr_enable = enable_q;
  assign bus.sr_pi     = pi_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_piso_tx_scheduler : directed bench with a frame-timing reference model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_piso_tx_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;
  int   ccount = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ccount <= ccount + 1;

  piso_tx_scheduler_if #(.N_REQ(3), .WIDTH(32)) ia ();
  piso_tx_scheduler_if #(.N_REQ(3), .WIDTH(4))  ib ();

  piso_tx_scheduler #(.N_REQ(3), .WIDTH(32), .CLK_DIV(4), .GAP_BITS(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ia)
  );
  piso_tx_scheduler #(.N_REQ(3), .WIDTH(4), .CLK_DIV(2), .GAP_BITS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ib)
  );

  // Reference: a frame is fully described by its LOAD cycle, winner and word.
  bit          act  [2];
  int          ld_cyc [2];
  int          win  [2];
  int          ptr  [2];
  logic [31:0] word [2];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, ccount);
    end
  endtask

  task automatic model_cycle(input int k, input int W, input int CD, input int GB,
                             input logic [2:0] rq, input logic [95:0] din,
                             input logic [2:0] g, input logic b, input logic d,
                             input logic ld, input logic en, input logic [31:0] pi);
    int          off, fr, j;
    bit          found;
    logic [2:0]  eg;
    logic        eb, ed, el, ee;
    logic [95:0] msk;
    string       p;
    p = (k == 0) ? "A" : "B";
    if (!reset_n) begin
      act[k]  = 1'b0;
      ptr[k]  = 0;
      word[k] = '0;
    end
    fr  = (W + GB) * CD;
    off = -1;
    eg = '0; eb = 1'b0; ed = 1'b0; el = 1'b0; ee = 1'b0;
    if (act[k]) begin
      off = ccount - ld_cyc[k];
      el  = (off == 0);
      eg  = (off == 0) ? 3'(1 << win[k]) : 3'b000;
      eb  = (off <= fr);
      ee  = (off == 0) || ((off <= fr) && (off % CD == 0));
      ed  = (off == fr + 1);
    end
    chk({p, " grant"},  {29'b0, g},   {29'b0, eg});
    chk({p, " busy"},   {31'b0, b},   {31'b0, eb});
    chk({p, " done"},   {31'b0, d},   {31'b0, ed});
    chk({p, " load"},   {31'b0, ld},  {31'b0, el});
    chk({p, " enable"}, {31'b0, en},  {31'b0, ee});
    chk({p, " pi"},     pi,           word[k]);
    if (reset_n && (!act[k] || off > fr) && (rq != 3'b000)) begin
      found = 1'b0;
      j = 0;
      for (int i = 0; i < 3; i++) begin
        if (!found && rq[(ptr[k] + i) % 3]) begin
          found = 1'b1;
          j = (ptr[k] + i) % 3;
        end
      end
      msk       = (96'h1 << W) - 96'h1;
      act[k]    = 1'b1;
      ld_cyc[k] = ccount + 1;
      win[k]    = j;
      word[k]   = 32'((din >> (j * W)) & msk);
      ptr[k]    = (j + 1) % 3;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, 32, 4, 2, ia.req, ia.data_in, ia.grant, ia.busy, ia.done,
                ia.sr_load, ia.sr_enable, ia.sr_pi);
    model_cycle(1, 4, 2, 0, ib.req, {84'b0, ib.data_in}, ib.grant, ib.busy, ib.done,
                ib.sr_load, ib.sr_enable, {28'b0, ib.sr_pi});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel: 0 A load, 1 A done, 2 B load, 3 B done, 4 any A grant
  task automatic wait_for(input int sel, input int lim, output int t);
    logic hit;
    t = -1;
    for (int i = 0; (i < lim) && (t < 0); i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = ia.sr_load;
        1:       hit = ia.done;
        2:       hit = ib.sr_load;
        3:       hit = ib.done;
        default: hit = |ia.grant;
      endcase
      if (hit) t = ccount;
    end
    if (t < 0) begin
      total++;
      bad++;
      $display("FAIL timeout sel=%0d: got no event, want one within %0d cycles", sel, lim);
    end
  endtask

  initial begin
    int         t0, t1, t2, tr, n;
    logic [2:0] eg [7];
    reset_n    = 1'b0;
    ia.req     = '0;
    ib.req     = '0;
    ia.data_in = {32'h3333_0003, 32'h2222_0002, 32'h0000_00A5};
    ib.data_in = {4'h9, 4'h6, 4'h5};
    step(3);
    chk("reset busy",  {31'b0, ia.busy}, 32'd0);
    chk("reset pi",    ia.sr_pi, 32'd0);
    chk("reset grant", {29'b0, ia.grant}, 32'd0);
    reset_n = 1'b1;
    step(1);

    // Short frame, no gap
    ib.req = 3'b001;
    wait_for(2, 10, t0);
    chk("B load grant", {29'b0, ib.grant}, 32'd1);
    chk("B load pi", {28'b0, ib.sr_pi}, 32'h5);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ib.sr_enable) n++;
    end
    chk("B enable pulses", n, 32'd4);
    wait_for(3, 4, t1);
    chk("B done latency", t1 - t0, 32'd9);
    wait_for(2, 4, t2);
    chk("B reload latency", t2 - t0, 32'd10);
    step(1);
    ib.req = 3'b000;

    // Single 32-bit frame with 2 gap bits
    ia.req = 3'b001;
    wait_for(0, 10, t0);
    chk("A load grant", {29'b0, ia.grant}, 32'd1);
    chk("A load pi", ia.sr_pi, 32'h0000_00A5);
    step(1);
    ia.req = 3'b000;
    n = 0;
    for (int i = 0; i < 136; i++) begin
      @(negedge clk);
      if (ia.sr_enable) n++;
    end
    chk("A enable pulses", n, 32'd34);
    wait_for(1, 4, t1);
    chk("A done latency", t1 - t0, 32'd137);

    // Round robin from a fresh pointer, then a changed request set
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    ia.req = 3'b111;
    eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    t1 = -1;
    for (int f = 0; f < 7; f++) begin
      wait_for(4, 150, t0);
      chk($sformatf("A grant order %0d", f), {29'b0, ia.grant}, {29'b0, eg[f]});
      if (f > 0) chk($sformatf("A load after done %0d", f), t0 - t1, 32'd1);
      if (f == 4) begin
        step(1);
        ia.req = 3'b101;
      end
      if (f < 6) wait_for(1, 150, t1);
    end

    // Asynchronous reset mid-shift
    repeat (42) @(posedge clk);
    #1;
    ia.req  = 3'b011;
    reset_n = 1'b0;
    #1;
    chk("async rst busy",   {31'b0, ia.busy}, 32'd0);
    chk("async rst enable", {31'b0, ia.sr_enable}, 32'd0);
    chk("async rst load",   {31'b0, ia.sr_load}, 32'd0);
    chk("async rst pi",     ia.sr_pi, 32'd0);
    chk("async rst grant",  {29'b0, ia.grant}, 32'd0);
    step(1);
    reset_n = 1'b1;
    tr = ccount;
    wait_for(4, 3, t0);
    chk("A grant after reset", {29'b0, ia.grant}, 32'd1);
    chk("A load one edge after release", t0 - tr, 32'd1);

    // Request pulse while busy is ignored
    step(1);
    ia.req = 3'b000;
    step(20);
    ia.req = 3'b100;
    step(1);
    ia.req = 3'b000;
    wait_for(1, 150, t1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ia.sr_load || ia.busy || (|ia.grant)) n++;
    end
    chk("A stays idle after pulse", n, 32'd0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
Round-robin scheduler that shares one shift_registers_piso serializer among N_REQ word producers.
- Arbitrates pending requests and drives the serializer's load and enable inputs.
- Paces shifting with an internal bit-rate divider and inserts idle-high gap bits between frames.
- Sits between the control/measurement logic that produces command words and the serial link output.

Parameters:
N_REQ, 3, number of requesters (>=1)
WIDTH, 32, frame width; must match serializer WIDTH (>=2)
CLK_DIV, 16, clk cycles per serial bit (>=2)
GAP_BITS, 2, idle bit times appended after each frame (>=0)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  level request per requester; hold until grant
data_in  in  N_REQ*WIDTH  requester i word at bits [i*WIDTH +: WIDTH]
grant  out  N_REQ  one-hot, 1-cycle pulse in the cycle the word is loaded
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse when frame plus gap completes
sr_load  out  1  to serializer load
sr_enable  out  1  to serializer enable
sr_pi  out  WIDTH  to serializer PI

Behaviour:
- Reset: asserting reset_n low immediately forces the following.
  - State = IDLE; grant, busy, done, sr_load, sr_enable = 0; sr_pi = 0.
  - Divider and bit counter = 0; round-robin pointer = 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If any req is high at a clock edge, select winner w and go to LOAD.
  - Winner w is the first requester with req high, searching upward from the pointer and wrapping modulo N_REQ.
  - req is sampled only in IDLE. It is never latched; a req that is low at that edge is ignored.
- LOAD (exactly 1 cycle):
  - sr_load = 1, sr_enable = 1, sr_pi = data_in word w (captured at the entry edge), grant[w] = 1.
  - Pointer updates to (w+1) mod N_REQ.
  - Divider cleared.
  - Next state: SHIFT.
- Bit-rate divider:
  - Counts 0..CLK_DIV-1 in SHIFT and GAP.
  - A tick occurs when the count reaches CLK_DIV-1, then the count wraps to 0.
  - The first tick falls CLK_DIV cycles after the LOAD cycle.
- SHIFT:
  - sr_enable is high for exactly the tick cycle; sr_load = 0.
  - bit_cnt increments on each tick.
  - On the WIDTH-th tick, clear bit_cnt and go to GAP, or to IDLE if GAP_BITS = 0.
- GAP:
  - Same enable pulsing, so the serializer fills with 1 and the line idles high.
  - After GAP_BITS ticks, go to IDLE.
- done:
  - Pulses in the first IDLE cycle after the frame.
  - If req is high in that cycle, the next LOAD follows immediately, so sr_load is asserted 1 cycle after done.
- Frame timing: LOAD at cycle L, last tick at L+(WIDTH+GAP_BITS)*CLK_DIV, done at L+(WIDTH+GAP_BITS)*CLK_DIV+1.
- sr_pi holds its value outside LOAD.
- Changes on req/data_in while busy have no effect.
- A granted requester may drop req after its grant; this does not affect the frame in progress.
- Reset mid-frame:
  - The frame is aborted; serializer contents are left as-is.
  - The next frame always starts with a LOAD, so no corruption carries over.
- Simultaneous requests: exactly one grant per frame; no requester is starved (bounded by N_REQ frames).

Test Plan:
1. WIDTH=32, CLK_DIV=4, GAP_BITS=2; req=3'b001, word0=0x000000A5 -> LOAD 1 cycle with grant=001, sr_pi=0x000000A5; 34 sr_enable pulses exactly 4 cycles apart (32 shift + 2 gap); done at L+137; busy high from L to L+136.
2. req=3'b111 held continuously with distinct words -> grants in order 001,010,100,001; each sr_load comes 1 cycle after the previous done.
3. After grant to requester 1, req=3'b101 -> next grant 100, then 001.
4. reset_n low during SHIFT at bit_cnt=10 -> all outputs 0 without waiting for a clock edge. Release with req=3'b011 -> grant=001 at the LOAD one edge later (pointer back to 0).
5. 1-cycle req[2] pulse while busy, low before done -> no grant[2], no extra frame; state returns to IDLE and stays there.
6. GAP_BITS=0, CLK_DIV=2, WIDTH=4, req=001 held -> 4 enable pulses 2 cycles apart; done at L+9; next sr_load at L+10.
